rx_display_sequencer: RTL and testbench

//  Controller between uart_receiver and the four-digit LED driver.
//  - Gates the receiver enable and assembles two received bytes (high byte, then low byte) into one 16-bit display word.
//  - Enforces an inter-byte timeout, substitutes an error pattern on parity/framing errors, and mutes the receiver for a recovery window after errors.
//  - Replaces the bare valid-gated register on the display path.

---
 rtl/rx_seq_pkg.sv | 29 ++
 rtl/rx_event_detect.sv | 27 ++
 rtl/rx_display_sequencer.sv | 119 +++++++++++
 tb/tb_rx_display_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rx_seq_pkg.sv
// Shared definitions for the UART receive-to-display sequencer:
// state encoding, default timing constants and the error display pattern.
package rx_seq_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_HI = 3'd1;
  localparam logic [2:0] ST_WAIT_LO = 3'd2;
  localparam logic [2:0] ST_ERR     = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WAIT_HI = ST_WAIT_HI,
    WAIT_LO = ST_WAIT_LO,
    ERR     = ST_ERR,
    HOLD    = ST_HOLD
  } state_t;

  localparam int          GAP_CYCLES_DEF  = 50_000;
  localparam int          HOLD_CYCLES_DEF = 10_000;
  localparam int          CNT_W_DEF       = 17;
  localparam logic [15:0] ERR_WORD_DEF    = 16'hEEEE;

  // Bad-frame counter sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_event_detect.sv
// Rising-edge detector on the receiver status lines: a held level yields a
// single event, classified good or bad by the error flags in that cycle.
module rx_event_detect (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic perror,
  input  logic ferror,
  output logic good_evt,
  output logic bad_evt
);

  logic line, line_q, evt, err;

  assign line = valid | perror | ferror;
  assign err  = perror | ferror;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) line_q <= 1'b0;
    else        line_q <= line;
  end

  assign evt      = line & ~line_q;
  assign bad_evt  = evt & err;
  assign good_evt = evt & ~err;

endmodule

// File: rtl/rx_display_sequencer.sv
// Gates the UART receiver, pairs hi/lo bytes into a 16-bit display word,
// aborts on inter-byte gaps and mutes the receiver for a flush window after errors.
module rx_display_sequencer
  import rx_seq_pkg::*;
#(
  parameter int          GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int          HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter logic [15:0] ERR_WORD    = ERR_WORD_DEF,
  parameter int          CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  Rx_DATA,
  input  logic        Rx_VALID,
  input  logic        Rx_PERROR,
  input  logic        Rx_FERROR,
  output logic        Rx_EN,
  output logic [15:0] display_word,
  output logic        frame_done,
  output logic        timeout,
  output logic [7:0]  err_count
);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [7:0]       hi;
  logic [CNT_W-1:0] cnt;
  logic             good_evt, bad_evt;

  rx_event_detect u_evt (
    .clk      (clk),
    .reset    (reset),
    .valid    (Rx_VALID),
    .perror   (Rx_PERROR),
    .ferror   (Rx_FERROR),
    .good_evt (good_evt),
    .bad_evt  (bad_evt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      Rx_EN        <= 1'b0;
      display_word <= 16'h0000;
      frame_done   <= 1'b0;
      timeout      <= 1'b0;
      err_count    <= 8'h00;
      hi           <= 8'h00;
      cnt          <= '0;
    end else begin
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          Rx_EN <= 1'b0;
          if (enable) begin
            state <= WAIT_HI;
            Rx_EN <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (!enable) begin
            state <= IDLE;
            Rx_EN <= 1'b0;
          end else if (bad_evt) begin
            state <= ERR;
          end else if (good_evt) begin
            hi    <= Rx_DATA;
            cnt   <= '0;
            state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          cnt <= cnt + 1'b1;
          // An event in the final gap cycle still wins over the timeout.
          if (!enable) begin
            state <= IDLE;
            Rx_EN <= 1'b0;
            hi    <= 8'h00;
          end else if (bad_evt) begin
            state <= ERR;
          end else if (good_evt) begin
            display_word <= {hi, Rx_DATA};
            frame_done   <= 1'b1;
            state        <= WAIT_HI;
          end else if (cnt == GAP_LAST) begin
            timeout <= 1'b1;
            hi      <= 8'h00;
            state   <= WAIT_HI;
          end
        end
        ERR: begin
          display_word <= ERR_WORD;
          err_count    <= sat_inc8(err_count);
          hi           <= 8'h00;
          cnt          <= '0;
          Rx_EN        <= 1'b0;
          state        <= HOLD;
        end
        HOLD: begin
          // The flush window always runs to completion; enable only picks the exit.
          cnt <= cnt + 1'b1;
          if (cnt == HOLD_LAST) begin
            state <= enable ? WAIT_HI : IDLE;
            Rx_EN <= enable;
          end
        end
        default: begin
          state <= IDLE;
          Rx_EN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_display_sequencer.sv
// Directed scoreboard bench for rx_display_sequencer with shortened gap/hold timing.
module tb_rx_display_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  Rx_DATA;
  logic        Rx_VALID, Rx_PERROR, Rx_FERROR;
  logic        Rx_EN;
  logic [15:0] display_word;
  logic        frame_done, timeout;
  logic [7:0]  err_count;

  typedef struct {
    bit          is_to;
    logic [15:0] word;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   low_cnt;

  rx_display_sequencer #(
    .GAP_CYCLES  (20),
    .HOLD_CYCLES (8),
    .ERR_WORD    (16'hEEEE),
    .CNT_W       (17)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .Rx_DATA      (Rx_DATA),
    .Rx_VALID     (Rx_VALID),
    .Rx_PERROR    (Rx_PERROR),
    .Rx_FERROR    (Rx_FERROR),
    .Rx_EN        (Rx_EN),
    .display_word (display_word),
    .frame_done   (frame_done),
    .timeout      (timeout),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic perr, input logic ferr, input int hold);
    @(negedge clk);
    Rx_DATA   = d;
    Rx_VALID  = ~(perr | ferr);
    Rx_PERROR = perr;
    Rx_FERROR = ferr;
    repeat (hold) @(negedge clk);
    Rx_VALID  = 1'b0;
    Rx_PERROR = 1'b0;
    Rx_FERROR = 1'b0;
  endtask

  task automatic push(input bit is_to, input logic [15:0] w);
    mon_e.is_to = is_to;
    mon_e.word  = w;
    sb.push_back(mon_e);
  endtask

  // Monitor: every frame_done/timeout pulse must match the next expectation.
  exp_t pop_e;
  always @(posedge clk) begin
    #1;
    if (frame_done || timeout) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: frame_done=%0b timeout=%0b expected no pulse", frame_done, timeout);
      end else begin
        pop_e = sb.pop_front();
        check("pulse_is_timeout", {31'b0, timeout}, {31'b0, pop_e.is_to});
        check("pulse_frame_done", {31'b0, frame_done}, {31'b0, ~pop_e.is_to});
        check("pulse_display", {16'b0, display_word}, {16'b0, pop_e.word});
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; Rx_DATA = 8'h00;
    Rx_VALID = 1'b0; Rx_PERROR = 1'b0; Rx_FERROR = 1'b0;
    #1;
    check("rst_rx_en", {31'b0, Rx_EN}, 0);
    check("rst_display", {16'b0, display_word}, 0);
    check("rst_frame_done", {31'b0, frame_done}, 0);
    check("rst_timeout", {31'b0, timeout}, 0);
    check("rst_err_count", {24'b0, err_count}, 0);
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;

    // 1: basic frame, VALID held 3 cycles
    send_byte(8'h12, 0, 0, 3);
    push(0, 16'h1234);
    send_byte(8'h34, 0, 0, 3);
    repeat (3) @(negedge clk);
    check("t1_err_count", {24'b0, err_count}, 0);
    check("t1_rx_en", {31'b0, Rx_EN}, 1);

    // 2: missing low byte -> timeout, display untouched; then a good frame
    send_byte(8'hAB, 0, 0, 3);
    push(1, 16'h1234);
    repeat (22) @(negedge clk);
    check("t2_display_kept", {16'b0, display_word}, 32'h1234);
    send_byte(8'hA1, 0, 0, 3);
    push(0, 16'hA1B2);
    send_byte(8'hB2, 0, 0, 3);
    repeat (3) @(negedge clk);

    // 3: parity error on low byte -> error word, receiver muted 8 cycles
    send_byte(8'h11, 0, 0, 3);
    @(negedge clk);
    Rx_DATA = 8'h22; Rx_VALID = 1'b1; Rx_PERROR = 1'b1;
    low_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (!Rx_EN) low_cnt++;
      if (k == 2) begin
        Rx_VALID = 1'b0; Rx_PERROR = 1'b0;
      end
    end
    check("t3_display_err", {16'b0, display_word}, 32'hEEEE);
    check("t3_err_count", {24'b0, err_count}, 1);
    check("t3_mute_cycles", low_cnt, 8);
    check("t3_rx_en_back", {31'b0, Rx_EN}, 1);

    // 4: low byte lands exactly in the last gap cycle -> accepted, no timeout
    send_byte(8'hC3, 0, 0, 3);
    repeat (16) @(negedge clk);
    push(0, 16'hC3D4);
    send_byte(8'hD4, 0, 0, 3);
    repeat (25) @(negedge clk);

    // 5: enable dropped after hi byte -> IDLE, then a fresh frame
    send_byte(8'h99, 0, 0, 3);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rx_en_off", {31'b0, Rx_EN}, 0);
    check("t5_display_kept", {16'b0, display_word}, 32'hC3D4);
    @(negedge clk);
    enable = 1'b1;
    send_byte(8'h56, 0, 0, 3);
    push(0, 16'h5678);
    send_byte(8'h78, 0, 0, 3);
    repeat (3) @(negedge clk);

    // 6: framing errors saturate err_count
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h00, 0, 1, 1);
      repeat (12) @(negedge clk);
    end
    check("t6_err_sat", {24'b0, err_count}, 32'hFF);
    check("t6_display_err", {16'b0, display_word}, 32'hEEEE);

    // async reset while waiting for the low byte
    send_byte(8'h42, 0, 0, 3);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_rx_en", {31'b0, Rx_EN}, 0);
    check("mid_rst_display", {16'b0, display_word}, 0);
    check("mid_rst_frame_done", {31'b0, frame_done}, 0);
    check("mid_rst_timeout", {31'b0, timeout}, 0);
    check("mid_rst_err_count", {24'b0, err_count}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send_byte(8'h0F, 0, 0, 3);
    push(0, 16'h0FF0);
    send_byte(8'hF0, 0, 0, 3);
    repeat (10) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
